// File: rtl/aes_pkg.sv
// Shared AES constants, byte type and GF(2^8) multiply helper used by the
// substitution datapath.
package aes_pkg;

    typedef logic [7:0] aes_byte_t;

    localparam aes_byte_t AES_POLY      = 8'h1B;
    localparam aes_byte_t AES_AFF_C     = 8'h63;
    localparam aes_byte_t AES_INV_AFF_C = 8'h05;

    // Shift-and-add multiply in GF(2^8), reducing by x^8+x^4+x^3+x+1 each step.
    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p;
        aes_byte_t t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end else begin
                p = p;
            end
            t = {t[6:0], 1'b0} ^ (t[7] ? AES_POLY : 8'h00);
        end
        return p;
    endfunction

    function automatic aes_byte_t gf_sq(input aes_byte_t a);
        return gf_mul(a, a);
    endfunction

endpackage

// File: rtl/aes_gf_inv.sv
// Combinational GF(2^8) multiplicative inverse as a^254; 0 maps to 0 naturally.
module aes_gf_inv
    import aes_pkg::*;
(
    input  aes_byte_t a,
    output aes_byte_t a_inv
);

    aes_byte_t p2_s, p3_s, p6_s, p7_s, p14_s, p15_s;
    aes_byte_t p30_s, p31_s, p62_s, p63_s, p126_s, p127_s;

    // Addition chain: 254 = 2*(2*(2*(2*(2*(2*3+1)+1)+1)+1)+1), one square per doubling.
    always_comb begin
        p2_s   = gf_sq(a);
        p3_s   = gf_mul(p2_s, a);
        p6_s   = gf_sq(p3_s);
        p7_s   = gf_mul(p6_s, a);
        p14_s  = gf_sq(p7_s);
        p15_s  = gf_mul(p14_s, a);
        p30_s  = gf_sq(p15_s);
        p31_s  = gf_mul(p30_s, a);
        p62_s  = gf_sq(p31_s);
        p63_s  = gf_mul(p62_s, a);
        p126_s = gf_sq(p63_s);
        p127_s = gf_mul(p126_s, a);
        a_inv  = gf_sq(p127_s);
    end

endmodule

// File: rtl/aes_sbox.sv
// Bidirectional AES S-box: one shared GF inverter with affine maps muxed on enc,
// plus a one-cycle registered copy of the result.
module aes_sbox
    import aes_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      enc,
    input  aes_byte_t sbox_in,
    output aes_byte_t sbox_out,
    output aes_byte_t sbox_out_q
);

    // Bit i collects b_i ^ b_(i+4..i+7); {b[k-1:0], b[7:k]} places b_(i+k) at bit i.
    function automatic aes_byte_t aff_fwd(input aes_byte_t b);
        return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]}
                 ^ {b[5:0], b[7:6]} ^ {b[6:0], b[7]} ^ AES_AFF_C;
    endfunction

    function automatic aes_byte_t aff_inv(input aes_byte_t b);
        return {b[1:0], b[7:2]} ^ {b[4:0], b[7:5]} ^ {b[6:0], b[7]} ^ AES_INV_AFF_C;
    endfunction

    aes_byte_t inv_in_s;
    aes_byte_t inv_out_s;
    aes_byte_t sbox_out_s;
    aes_byte_t sbox_out_q_r;

    // Inverter input: raw byte for forward, un-affined byte for inverse.
    always_comb begin
        inv_in_s = sbox_in;
        if (enc) begin
            inv_in_s = sbox_in;
        end else begin
            inv_in_s = aff_inv(sbox_in);
        end
    end

    aes_gf_inv u_gf_inv (
        .a     (inv_in_s),
        .a_inv (inv_out_s)
    );

    // Output select: affine of the inverse for forward, bare inverse otherwise.
    always_comb begin
        sbox_out_s = inv_out_s;
        if (enc) begin
            sbox_out_s = aff_fwd(inv_out_s);
        end else begin
            sbox_out_s = inv_out_s;
        end
    end

    // Pipeline copy; reset clears it asynchronously and drops any in-flight value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbox_out_q_r <= 8'h00;
        end else begin
            sbox_out_q_r <= sbox_out_s;
        end
    end

    assign sbox_out   = sbox_out_s;
    assign sbox_out_q = sbox_out_q_r;

endmodule

// File: tb/tb_aes_sbox.sv
// Self-checking bench for aes_sbox against a table model built from field arithmetic.
module tb_aes_sbox;

    logic       clk;
    logic       rst;
    logic       enc;
    logic [7:0] sbox_in;
    logic [7:0] sbox_out;
    logic [7:0] sbox_out_q;

    int checks;
    int errors;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    aes_sbox dut (
        .clk        (clk),
        .rst        (rst),
        .enc        (enc),
        .sbox_in    (sbox_in),
        .sbox_out   (sbox_out),
        .sbox_out_q (sbox_out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Carry-less product to 15 bits, then long-division reduction by 0x11B.
    function automatic logic [7:0] mdl_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int k = 15; k >= 8; k--)
            if (p[k]) p = p ^ (16'h011B << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] w;
        w = {b, b} << n;
        return w[15:8];
    endfunction

    task automatic build_model();
        logic [7:0] iv;
        for (int x = 0; x < 256; x++) begin
            iv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mdl_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            fwd_tab[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    function automatic logic [7:0] model(input logic e, input logic [7:0] x);
        return e ? fwd_tab[x] : inv_tab[x];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] fv_in  [5] = '{8'h00, 8'hAB, 8'h0D, 8'h8F, 8'h33};
    logic [7:0] fv_out [5] = '{8'h63, 8'h62, 8'hD7, 8'h73, 8'hC3};
    logic [7:0] iv_out [5] = '{8'h52, 8'h0E, 8'hF3, 8'h73, 8'h66};

    initial begin
        logic [7:0]   y;
        logic [255:0] seen;
        int           bad_fix;
        int           n_seen;
        logic         e;
        logic [7:0]   prev_q;

        checks = 0;
        errors = 0;
        build_model();

        rst = 1'b1; enc = 1'b1; sbox_in = 8'h00;
        #1;
        check("reset_q", {8'h00, sbox_out_q}, 16'h0000);
        check("reset_comb", {8'h00, sbox_out}, 16'h0063);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            enc = 1'b1; sbox_in = fv_in[i]; #1;
            check($sformatf("fwd_vec_%02h", fv_in[i]), {8'h00, sbox_out}, {8'h00, fv_out[i]});
            enc = 1'b0; #1;
            check($sformatf("inv_vec_%02h", fv_in[i]), {8'h00, sbox_out}, {8'h00, iv_out[i]});
        end

        seen = '0;
        bad_fix = 0;
        for (int x = 0; x < 256; x++) begin
            enc = 1'b1; sbox_in = 8'(x); #1;
            y = sbox_out;
            check($sformatf("fwd_all_%02h", x), {8'h00, y}, {8'h00, model(1'b1, 8'(x))});
            seen[y] = 1'b1;
            if (y == 8'(x) || y == (8'(x) ^ 8'hFF)) bad_fix++;
            enc = 1'b0; sbox_in = y; #1;
            check($sformatf("inv_fwd_rt_%02h", x), {8'h00, sbox_out}, 16'(x));
            sbox_in = 8'(x); #1;
            y = sbox_out;
            check($sformatf("inv_all_%02h", x), {8'h00, y}, {8'h00, model(1'b0, 8'(x))});
            enc = 1'b1; sbox_in = y; #1;
            check($sformatf("fwd_inv_rt_%02h", x), {8'h00, sbox_out}, 16'(x));
        end
        n_seen = 0;
        for (int i = 0; i < 256; i++) if (seen[i]) n_seen++;
        check("perm_count", 16'(n_seen), 16'd256);
        check("fixed_or_anti", 16'(bad_fix), 16'd0);

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            e = 1'($urandom_range(0, 1));
            enc = e; sbox_in = 8'($urandom_range(0, 255)); #1;
            check("rand_comb", {8'h00, sbox_out}, {8'h00, model(e, sbox_in)});
            @(posedge clk); #1;
            check("rand_q", {8'h00, sbox_out_q}, {8'h00, model(e, sbox_in)});
        end

        @(negedge clk); enc = 1'b1; sbox_in = 8'h8F;
        @(posedge clk); #1;
        check("reg_fwd_8f", {8'h00, sbox_out_q}, 16'h0073);
        @(negedge clk); enc = 1'b0; sbox_in = 8'h8F;
        @(posedge clk); #1;
        check("reg_inv_8f", {8'h00, sbox_out_q}, 16'h0073);

        @(negedge clk); enc = 1'b1; sbox_in = 8'hAB;
        @(posedge clk); #1;
        check("pre_rst_q", {8'h00, sbox_out_q}, 16'h0062);
        #2 rst = 1'b1; #1;
        check("async_rst_q", {8'h00, sbox_out_q}, 16'h0000);
        check("async_rst_comb", {8'h00, sbox_out}, 16'h0062);
        @(posedge clk); #1;
        check("rst_hold_q", {8'h00, sbox_out_q}, 16'h0000);
        @(negedge clk); rst = 1'b0; #1;
        check("rst_release_q", {8'h00, sbox_out_q}, 16'h0000);
        @(posedge clk); #1;
        check("first_load_q", {8'h00, sbox_out_q}, 16'h0062);

        prev_q = 8'h62;
        e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            enc = e; sbox_in = 8'h00; #1;
            check("toggle_comb", {8'h00, sbox_out}, e ? 16'h0063 : 16'h0052);
            check("toggle_q_lag", {8'h00, sbox_out_q}, {8'h00, prev_q});
            @(posedge clk); #1;
            check("toggle_q", {8'h00, sbox_out_q}, e ? 16'h0063 : 16'h0052);
            prev_q = e ? 8'h63 : 8'h52;
            e = ~e;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_sbox.md
# aes_sbox

Bidirectional AES byte substitution unit: forward S-box (SubBytes) when `enc`=1 and inverse S-box (InvSubBytes) when `enc`=0, per FIPS-197. It is the leaf substitution primitive instantiated by the AES round datapath and the key-expansion logic. It has two outputs: a zero-latency combinational result, and a one-cycle registered copy for pipelined callers.

## Interface
Parameters:
- None. Field polynomial x^8+x^4+x^3+x+1 (0x11B) is fixed.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enc`  in  1  1 = forward S-box, 0 = inverse S-box.
- `sbox_in`  in  8  input byte.
- `sbox_out`  out  8  combinational substitution of `sbox_in` under `enc`.
- `sbox_out_q`  out  8  `sbox_out` registered on `clk`.

## Operation
- Forward (`enc`=1): `sbox_out` = A(inv(x)).
  - inv = multiplicative inverse in GF(2^8) mod 0x11B, with inv(0x00)=0x00.
  - A = FIPS-197 affine map: b_i ^ b_(i+4) ^ b_(i+5) ^ b_(i+6) ^ b_(i+7) ^ c_i, indices mod 8, c = 0x63.
- Inverse (`enc`=0): `sbox_out` = inv(A^-1(x)).
  - A^-1: b_(i+2) ^ b_(i+5) ^ b_(i+7) ^ d_i, indices mod 8, d = 0x05.
- Datapath sharing:
  - One GF inverter is shared by both directions.
  - A 2:1 mux on `enc` selects the inverter input: x, or A^-1(x).
  - A 2:1 mux on `enc` selects the output: A(inv), or inv.
- Implementation is free to use either a composite-field GF((2^4)^2) inverter or an exponentiation chain (x^254). The result must be bit-exact with the FIPS-197 tables for all 512 (enc, byte) combinations.
- `sbox_out` is purely combinational. It has no latches and no dependence on `clk` or `rst`.
- `enc` may change on any cycle; there is no mode state.

## Timing
- `sbox_out`: 0-cycle latency; follows `sbox_in` and `enc` combinationally.
- `sbox_out_q`: loads `sbox_out` on every rising `clk`; 1-cycle latency; no enable.
- Reset:
  - `rst`=1 forces `sbox_out_q` = 0x00 immediately, without waiting for a clock edge.
  - The register holds 0x00 while `rst` is high.
  - The first load occurs on the first rising edge after `rst` deasserts.
- Reset asserted mid-stream: the in-flight registered value is discarded. `sbox_out` is unaffected by reset.
- Changing `enc` and `sbox_in` in the same cycle: `sbox_out_q` on the next edge reflects both new values.

## Structure
- Shared package `aes_pkg`:
  - `AES_POLY` = 8'h1B (reduction constant).
  - `AES_AFF_C` = 8'h63.
  - `AES_INV_AFF_C` = 8'h05.
  - Byte typedef `aes_byte_t`.
- Sub-module `aes_gf_inv`: combinational GF(2^8) inverse, 8-bit in and 8-bit out, with 0→0.
- Affine and inverse-affine maps are local functions in `aes_sbox`.

## Test plan
- Forward vectors (`enc`=1), combinational: 00→63, AB→62, 0D→D7, 8F→73, 33→C3 on `sbox_out`.
- Inverse vectors (`enc`=0), combinational: 00→52, AB→0E, 0D→F3, 8F→73, 33→66 on `sbox_out`.
- Exhaustive round trip, for all x in 00..FF:
  - InvS(S(x)) = x.
  - S(InvS(x)) = x.
  - Forward outputs form a permutation, with no fixed points and no x such that S(x) = x ^ 0xFF.
- Registered path: drive 8F with `enc`=1, then 8F with `enc`=0 on consecutive cycles → `sbox_out_q` = 73, then 73, each one edge later.
- Async reset: hold input AB/`enc`=1 and assert `rst` between clock edges → `sbox_out_q` = 00 immediately while `sbox_out` stays 62. After `rst` deasserts, the first edge loads 62.
- Mode toggling: hold `sbox_in`=00 and toggle `enc` every cycle → `sbox_out` alternates 63/52 with zero delay, and `sbox_out_q` follows one cycle later.
